// File: rtl/ysyx_25040111_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_arb_pkg
// Purpose  : Shared types and constants for the IFU/LSU memory arbiter.
//            - arb_state_e      : arbiter FSM states
//            - GNT_IF / GNT_LS  : encoding of the last-served requester
//            - ERR_DATA_DEFAULT : read data returned on a watchdog timeout
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25040111_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_e;

  localparam logic GNT_IF = 1'b1;
  localparam logic GNT_LS = 1'b0;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/ysyx_25040111_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_arb_timer
// Purpose  : Watchdog counter for one outstanding memory transaction.
// Ports    : clk    in  core clock
//            reset  in  asynchronous active-high reset
//            clr    in  restart the count at zero (transaction granted)
//            en     in  count this cycle (transaction in flight)
//            expire out high while enabled in the TIMEOUT-th counted cycle
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter parks at LAST; the arbiter always leaves BUSY on expiry,
  // so it never needs to wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/ysyx_25040111_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_mem_arbiter
// Purpose  : Round-robin arbiter sharing one memory port between the IFU and
//            the LSU, one transaction outstanding, with a watchdog timeout.
// Ports    : clk, reset                 clock, async active-high reset
//            ifu_req/addr -> ifu_rdata/ok  instruction fetch requester
//            lsu_req/wen/addr/wdata/wmask -> lsu_rdata/ok  load/store requester
//            mem_start/wen/addr/wdata/wmask, mem_rdata/ok  downstream port
//            bus_err      sticky timeout flag
//            conflict_cnt saturating count of IDLE cycles with a tie
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_mem_arbiter
  import ysyx_25040111_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic [31:0] ifu_rdata,
  output logic        ifu_ok,
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic [31:0] lsu_rdata,
  output logic        lsu_ok,
  output logic        mem_start,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ok,
  output logic        bus_err,
  output logic [31:0] conflict_cnt
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] conflict_q, conflict_d;
  logic        mem_start_q, mem_start_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        ifu_ok_q, ifu_ok_d;
  logic        lsu_ok_q, lsu_ok_d;
  logic        bus_err_q, bus_err_d;

  logic        ifu_elig, lsu_elig;
  logic        grant, grant_if;
  logic        timer_expire;
  logic [31:0] done_data;

  // A requester whose ok is high this cycle still shows req; masking it
  // prevents a second grant before it has had a chance to drop req.
  assign ifu_elig  = ifu_req && !ifu_ok_q;
  assign lsu_elig  = lsu_req && !lsu_ok_q;
  // mem_ok on the expiry cycle wins over the timeout.
  assign done_data = mem_ok ? mem_rdata : ERR_DATA;

  ysyx_25040111_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant),
    .en     (state_q != IDLE),
    .expire (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    conflict_d   = conflict_q;
    mem_start_d  = 1'b0;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    ifu_ok_d     = 1'b0;
    lsu_ok_d     = 1'b0;
    bus_err_d    = bus_err_q;
    grant        = 1'b0;
    grant_if     = 1'b0;

    case (state_q)
      IDLE: begin
        grant = ifu_elig || lsu_elig;
        if (ifu_elig && lsu_elig) begin
          grant_if = (last_grant_q == GNT_LS);
          if (conflict_q != 32'hFFFF_FFFF) begin
            conflict_d = conflict_q + 32'd1;
          end
        end else begin
          grant_if = ifu_elig;
        end

        if (grant) begin
          mem_start_d  = 1'b1;
          last_grant_d = grant_if ? GNT_IF : GNT_LS;
          if (grant_if) begin
            state_d     = BUSY_IF;
            mem_wen_d   = 1'b0;
            mem_addr_d  = ifu_addr;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
          end else begin
            state_d     = BUSY_LS;
            mem_wen_d   = lsu_wen;
            mem_addr_d  = lsu_addr;
            mem_wdata_d = lsu_wdata;
            mem_wmask_d = lsu_wmask;
          end
        end
      end

      BUSY_IF, BUSY_LS: begin
        if (mem_ok || timer_expire) begin
          state_d = IDLE;
          if (!mem_ok) begin
            bus_err_d = 1'b1;
          end
          if (state_q == BUSY_IF) begin
            ifu_ok_d    = 1'b1;
            ifu_rdata_d = done_data;
          end else begin
            lsu_ok_d = 1'b1;
            if (!mem_wen_q) begin
              lsu_rdata_d = done_data;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_LS;
      conflict_q   <= '0;
      mem_start_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
      ifu_ok_q     <= 1'b0;
      lsu_ok_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
      mem_start_q  <= mem_start_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      ifu_ok_q     <= ifu_ok_d;
      lsu_ok_q     <= lsu_ok_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign ifu_rdata    = ifu_rdata_q;
  assign ifu_ok       = ifu_ok_q;
  assign lsu_rdata    = lsu_rdata_q;
  assign lsu_ok       = lsu_ok_q;
  assign mem_start    = mem_start_q;
  assign mem_wen      = mem_wen_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wmask    = mem_wmask_q;
  assign bus_err      = bus_err_q;
  assign conflict_cnt = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040111_mem_arbiter
// Purpose  : Self-checking bench for the IFU/LSU memory arbiter (TIMEOUT=8).
//            Requester and memory models run in one monitor process; expected
//            completions are queued when a request is issued and popped when
//            the matching ok pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic [31:0] ifu_rdata;
  logic        ifu_ok;
  logic        lsu_req;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic [31:0] lsu_rdata;
  logic        lsu_ok;
  logic        mem_start;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ok;
  logic        bus_err;
  logic [31:0] conflict_cnt;

  ysyx_25040111_mem_arbiter #(
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ifu_req      (ifu_req),
    .ifu_addr     (ifu_addr),
    .ifu_rdata    (ifu_rdata),
    .ifu_ok       (ifu_ok),
    .lsu_req      (lsu_req),
    .lsu_wen      (lsu_wen),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_rdata    (lsu_rdata),
    .lsu_ok       (lsu_ok),
    .mem_start    (mem_start),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata),
    .mem_ok       (mem_ok),
    .bus_err      (bus_err),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_ifu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          is_ifu;
    logic [31:0] rdata;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] grant_log[$];

  int n_checks = 0;
  int n_pass   = 0;

  int ifu_pending = 0;
  int lsu_pending = 0;
  int cyc = 0;
  int starts = 0;
  int ok_count = 0;
  int ifu_ok_cyc = 0;
  int lsu_ok_cyc = 0;
  int last_start_cyc = 0;

  int          resp_delay = 0;
  int          resp_cnt = 0;
  bit          resp_never = 0;
  bit          resp_active = 0;
  logic [31:0] resp_rdata = '0;
  bit          chk_stable = 0;
  bit          in_busy = 0;
  logic        cap_wen;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wmask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'(|{ifu_rdata, ifu_ok, lsu_rdata, lsu_ok, mem_start, mem_wen,
                    mem_addr, mem_wdata, mem_wmask, bus_err, conflict_cnt}), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!(ifu_pending == 0 && lsu_pending == 0 && sb.size() == 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done", 32'(ifu_pending == 0 && lsu_pending == 0 && sb.size() == 0), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ifu_pending = 0;
    lsu_pending = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Requester models, memory model and completion scoreboard.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ifu_ok || lsu_ok) begin
      ok_count++;
      chk("single_ok", 32'(ifu_ok && lsu_ok), 32'd0);
      chk("ok_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ok_owner", 32'(ifu_ok), 32'(mon_e.is_ifu));
        chk("ok_rdata", ifu_ok ? ifu_rdata : lsu_rdata, mon_e.rdata);
      end
      if (ifu_ok) begin
        ifu_ok_cyc = cyc;
        if (ifu_pending > 0) ifu_pending--;
      end
      if (lsu_ok) begin
        lsu_ok_cyc = cyc;
        if (lsu_pending > 0) lsu_pending--;
      end
    end
    ifu_req = (ifu_pending > 0);
    lsu_req = (lsu_pending > 0);

    if (chk_stable && in_busy && !mem_start) begin
      chk("mem_fields_stable",
          32'({mem_wen, mem_addr, mem_wdata, mem_wmask} == {cap_wen, cap_addr, cap_wdata, cap_wmask}),
          32'd1);
    end

    mem_ok = 1'b0;
    if (mem_start) begin
      starts++;
      cap_wen   = mem_wen;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
      cap_wmask = mem_wmask;
      grant_log.push_back(mem_addr);
      last_start_cyc = cyc;
      in_busy     = 1'b1;
      resp_cnt    = resp_delay;
      resp_active = !resp_never;
    end
    if (resp_active) begin
      if (resp_cnt == 0) begin
        mem_ok      = 1'b1;
        mem_rdata   = resp_rdata;
        resp_active = 1'b0;
        in_busy     = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int okb;
    int k;

    //        is_ifu wen  addr           wdata          wmask    rdata          dly exp
    vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         4'h0,    32'h0000_0413, 2, 32'h0000_0413};
    vecs[1] = '{1'b0, 1'b0, 32'h8000_0100, 32'h0,         4'h0,    32'h1234_5678, 0, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 32'hA000_03F8, 32'h0000_0041, 4'b0001, 32'h5555_5555, 3, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h8000_0004, 32'h0,         4'h0,    32'h0050_0093, 1, 32'h0050_0093};
    vecs[4] = '{1'b0, 1'b0, 32'h8000_0200, 32'h0,         4'h0,    32'hCAFE_F00D, 7, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0008, 32'h0,         4'h0,    32'h0000_0013, 6, 32'h0000_0013};

    reset     = 1'b1;
    ifu_req   = 1'b0;
    ifu_addr  = '0;
    lsu_req   = 1'b0;
    lsu_wen   = 1'b0;
    lsu_addr  = '0;
    lsu_wdata = '0;
    lsu_wmask = '0;
    mem_rdata = '0;
    mem_ok    = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;

    // Single transactions; delay 7 lands mem_ok on the expiry cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      resp_delay = vecs[i].delay;
      resp_rdata = vecs[i].rdata;
      resp_never = 1'b0;
      chk_stable = vecs[i].wen && !vecs[i].is_ifu;
      base = starts;
      if (vecs[i].is_ifu) begin
        ifu_addr = vecs[i].addr;
      end else begin
        lsu_wen   = vecs[i].wen;
        lsu_addr  = vecs[i].addr;
        lsu_wdata = vecs[i].wdata;
        lsu_wmask = vecs[i].wmask;
      end
      sb.push_back('{vecs[i].is_ifu, vecs[i].exp});
      if (vecs[i].is_ifu) ifu_pending = 1;
      else lsu_pending = 1;
      wait_done(100);
      chk($sformatf("v%0d_accesses", i), 32'(starts - base), 32'd1);
      chk($sformatf("v%0d_addr", i), cap_addr, vecs[i].addr);
      chk($sformatf("v%0d_wen", i), 32'(cap_wen), 32'(vecs[i].is_ifu ? 1'b0 : vecs[i].wen));
      chk($sformatf("v%0d_wmask", i), 32'(cap_wmask), 32'(vecs[i].is_ifu ? 4'h0 : vecs[i].wmask));
      if (!vecs[i].is_ifu && vecs[i].wen) begin
        chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].wdata);
      end
    end
    chk_stable = 1'b0;
    chk("table_bus_err", 32'(bus_err), 32'd0);
    chk("table_conflicts", conflict_cnt, 32'd0);

    // Tie straight after reset: IFU first, LSU granted in the IFU ok cycle.
    do_reset();
    @(negedge clk);
    grant_log.delete();
    resp_delay = 1;
    resp_rdata = 32'hA5A5_0001;
    ifu_addr   = 32'h8000_1000;
    lsu_wen    = 1'b0;
    lsu_addr   = 32'h9000_0000;
    sb.push_back('{1'b1, 32'hA5A5_0001});
    sb.push_back('{1'b0, 32'hA5A5_0001});
    ifu_pending = 1;
    lsu_pending = 1;
    wait_done(100);
    chk("tie_conflict_cnt", conflict_cnt, 32'd1);
    chk("tie_first_grant", (grant_log.size() > 0) ? grant_log[0] : 32'h0, 32'h8000_1000);
    chk("tie_no_gap", 32'(last_start_cyc - ifu_ok_cyc), 32'd1);

    // Sustained demand from both sides alternates grants.
    @(negedge clk);
    grant_log.delete();
    resp_delay = 2;
    resp_rdata = 32'h1111_2222;
    ifu_addr   = 32'h8000_3000;
    lsu_addr   = 32'h9000_3000;
    for (int i = 0; i < 6; i++) sb.push_back('{(i % 2) == 0, 32'h1111_2222});
    ifu_pending = 3;
    lsu_pending = 3;
    wait_done(200);
    chk("rr_grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) begin
        chk($sformatf("rr_grant%0d", i), grant_log[i],
            ((i % 2) == 0) ? 32'h8000_3000 : 32'h9000_3000);
      end
    end
    chk("rr_conflict_cnt", conflict_cnt, 32'd2);

    // Watchdog: no mem_ok ever; LSU load aborts after 8 BUSY cycles.
    @(negedge clk);
    resp_never = 1'b1;
    lsu_wen    = 1'b0;
    lsu_addr   = 32'h9000_0040;
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    lsu_pending = 1;
    wait_done(100);
    chk("timeout_latency", 32'(lsu_ok_cyc - last_start_cyc), 32'd8);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    @(negedge clk);
    resp_never = 1'b0;
    resp_delay = 1;
    resp_rdata = 32'h0000_0297;
    ifu_addr   = 32'h8000_0010;
    sb.push_back('{1'b1, 32'h0000_0297});
    ifu_pending = 1;
    wait_done(100);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // Asynchronous reset in the middle of a BUSY period.
    @(negedge clk);
    resp_delay = 4;
    resp_rdata = 32'h7777_7777;
    lsu_addr   = 32'h9000_0080;
    base = starts;
    sb.push_back('{1'b0, 32'h7777_7777});
    lsu_pending = 1;
    k = 0;
    while (starts == base && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("abort_started", 32'(starts != base), 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    lsu_pending = 0;
    sb.delete();
    #1;
    chk_all_zero("abort_outputs_zero");
    okb = ok_count;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_ok", 32'(ok_count - okb), 32'd0);
    chk("abort_lsu_rdata", lsu_rdata, 32'd0);
    resp_delay = 2;
    resp_rdata = 32'h0000_0073;
    ifu_addr   = 32'h8000_2000;
    sb.push_back('{1'b1, 32'h0000_0073});
    ifu_pending = 1;
    wait_done(100);
    chk("after_abort_bus_err", 32'(bus_err), 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25040111_mem_arbiter.md
Name: ysyx_25040111_mem_arbiter

Overview:
Shares the single core memory port between the instruction fetch path (IFU) and the load/store path (LSU). Requesters use a level request held until a one-cycle ok pulse. The downstream port uses a one-cycle start pulse and a one-cycle ok pulse. Arbitration is round-robin, one transaction outstanding at a time, with a watchdog timeout that reports stuck transactions.

Parameters:
TIMEOUT, 255, number of BUSY cycles without mem_ok before the transaction is aborted; must be >= 2
ERR_DATA, 32'hDEAD_BEEF, read data returned to the requester on timeout

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
ifu_req  in  1  IFU fetch request; level, held until ifu_ok
ifu_addr  in  32  fetch address
ifu_rdata  out  32  fetched instruction; valid when ifu_ok=1
ifu_ok  out  1  one-cycle completion pulse for IFU
lsu_req  in  1  LSU request; level, held until lsu_ok
lsu_wen  in  1  1=store, 0=load
lsu_addr  in  32  access address
lsu_wdata  in  32  store data
lsu_wmask  in  4  byte enables for stores
lsu_rdata  out  32  load data; valid when lsu_ok=1
lsu_ok  out  1  one-cycle completion pulse for LSU
mem_start  out  1  one-cycle pulse starting a downstream access
mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/32/32/4  latched access fields; stable for the whole BUSY period
mem_rdata  in  32  downstream read data; sampled when mem_ok=1
mem_ok  in  1  downstream completion pulse
bus_err  out  1  sticky; set on any timeout
conflict_cnt  out  32  saturating count of IDLE cycles in which both requests were eligible

Behaviour:
- Reset (async, active-high) drives all of the following to 0: every output, state=IDLE, timer, last_grant. last_grant=0 means LSU was served last, so IFU wins the first tie.
- States:
  - IDLE
  - BUSY_IF
  - BUSY_LS
- Eligibility in IDLE: a request is eligible when its req=1 and its own ok is not high this cycle. This blocks re-issue before the requester drops req.
- IDLE, one eligible request -> that requester is granted.
- IDLE, both eligible -> grant the requester not in last_grant, then update last_grant; conflict_cnt += 1, saturating at 32'hFFFF_FFFF.
- Grant cycle N:
  - next state is BUSY_x;
  - the mem_* fields are latched from x;
  - mem_start=1 during cycle N+1 only.
  - IFU grants force mem_wen=0 and mem_wmask=0 (fetch is always a read).
- BUSY_x, mem_ok=1 at cycle M:
  - x_rdata <= mem_rdata for reads; lsu_rdata holds its previous value for stores;
  - x_ok=1 during cycle M+1;
  - state=IDLE in cycle M+1.
- Minimum turnaround: req to ok is 3 cycles when mem_ok arrives in the same cycle as mem_start.
- mem_ok in the same cycle as mem_start is legal and completes the transaction.
- mem_ok while IDLE (stale or spurious) is ignored; no output changes.
- Timer:
  - cleared on entering BUSY_x, increments each BUSY cycle;
  - if it reaches TIMEOUT-1 with mem_ok=0: x_rdata <= ERR_DATA (reads only), x_ok pulses next cycle, bus_err <= 1, state=IDLE;
  - mem_ok in that same cycle wins: normal completion, no error.
- bus_err clears only on reset.
- Request fields are sampled only at grant; requester changes during BUSY are ignored.
- Reset mid-transaction abandons it immediately; a later mem_ok arrives in IDLE and is ignored.
- Dropping req while BUSY does not abort the transaction; the ok pulse is still issued.

Decomposition:
- Package ysyx_25040111_arb_pkg:
  - state enum (IDLE/BUSY_IF/BUSY_LS);
  - grant encoding constants GNT_IF=1, GNT_LS=0;
  - default ERR_DATA constant.
- Sub-module ysyx_25040111_arb_timer: watchdog counter with inputs clr/en and output expire.
  - Counter width $clog2(TIMEOUT+1).
  - Parameterised by TIMEOUT.
  - Async reset.
- Remainder is one FSM plus datapath registers.

Test Plan:
- IFU alone: ifu_req=1, addr=0x8000_0000; mem_ok with rdata=0x0000_0413 two cycles after mem_start -> mem_start is a single pulse with mem_wen=0; ifu_rdata=0x0000_0413; ifu_ok is a single pulse; exactly one access.
- Tie after reset: ifu_req and lsu_req rise in the same cycle -> IFU served first, then LSU, with no idle gap beyond the ok cycle; conflict_cnt=1.
- Sustained both-requests for 6 transactions (each requester re-requesting immediately) -> grants alternate IF, LS, IF, LS, IF, LS.
- LSU store: addr=0xA000_03F8, wdata=0x0000_0041, wmask=4'b0001 -> mem fields match and stay stable through BUSY; lsu_ok pulses; lsu_rdata unchanged.
- Timeout with TIMEOUT=8 and mem_ok never asserted -> after 8 BUSY cycles, lsu_ok pulses with lsu_rdata=0xDEAD_BEEF and bus_err=1; a following normal access completes and bus_err stays 1.
- Async reset asserted mid-BUSY, then mem_ok pulsed after release -> all outputs 0, state IDLE, no ok pulse; the next request is served normally.
